// File: rtl/hd44780_byte_sequencer.sv
// HD44780 4-bit controller: power-on init sequence, then byte transfers
// split into two nybble-sender strobes followed by the LCD execution delay.
module hd44780_byte_sequencer #(
  parameter int T_POWERUP = 180000,
  parameter int T_INIT1   = 49200,
  parameter int T_INIT2   = 1200,
  parameter int T_CMD     = 480,
  parameter int T_LONG    = 19680
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       STB_I,
  input  logic       i_rs,
  input  logic [7:0] i_byte,
  output logic       o_busy,
  output logic       o_init_done,
  output logic       o_ns_stb,
  output logic       o_ns_rs,
  output logic [3:0] o_ns_nybble,
  input  logic       i_ns_busy
);

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMAX = mx(mx(mx(T_POWERUP, T_INIT1), mx(T_INIT2, T_CMD)), T_LONG);
  localparam int CW   = $clog2(TMAX + 2);

  typedef enum logic [2:0] {PWRWAIT, INIT_SEND, NS_WAIT, DELAY, IDLE, SEND_LO} state_t;
  typedef enum logic [1:0] {PH_INIT, PH_HI, PH_LO} phase_t;

  state_t        state, state_n;
  phase_t        phase, phase_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx, idx_n;
  logic          rs_q, rs_n, long_q, long_n, first_q, first_n;
  logic [7:0]    byte_q, byte_n;
  logic          busy_n, done_n, stb_n, ns_rs_n;
  logic [3:0]    nyb_n;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state       <= PWRWAIT;
      phase       <= PH_INIT;
      cnt         <= CW'(T_POWERUP);
      idx         <= 2'd0;
      rs_q        <= 1'b0;
      long_q      <= 1'b0;
      first_q     <= 1'b0;
      byte_q      <= 8'h00;
      o_busy      <= 1'b1;
      o_init_done <= 1'b0;
      o_ns_stb    <= 1'b0;
      o_ns_rs     <= 1'b0;
      o_ns_nybble <= 4'h0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      rs_q        <= rs_n;
      long_q      <= long_n;
      first_q     <= first_n;
      byte_q      <= byte_n;
      o_busy      <= busy_n;
      o_init_done <= done_n;
      o_ns_stb    <= stb_n;
      o_ns_rs     <= ns_rs_n;
      o_ns_nybble <= nyb_n;
    end
  end

  // Outputs are registered: each strobe is set on the edge that makes the
  // decision, so o_ns_rs/o_ns_nybble only ever change together with o_ns_stb.
  always_comb begin
    state_n = state;
    phase_n = phase;
    cnt_n   = cnt;
    idx_n   = idx;
    rs_n    = rs_q;
    long_n  = long_q;
    byte_n  = byte_q;
    first_n = 1'b0;
    done_n  = o_init_done;
    stb_n   = 1'b0;
    ns_rs_n = o_ns_rs;
    nyb_n   = o_ns_nybble;
    case (state)
      PWRWAIT: begin
        if (cnt <= CW'(1)) begin
          state_n = INIT_SEND;
          phase_n = PH_INIT;
          stb_n   = 1'b1;
          ns_rs_n = 1'b0;
          nyb_n   = 4'h3;
        end else cnt_n = cnt - CW'(1);
      end
      INIT_SEND, SEND_LO: begin
        state_n = NS_WAIT;
        first_n = 1'b1;
      end
      NS_WAIT: begin
        // First cycle skipped: the sender has not yet seen the strobe.
        if (!first_q && !i_ns_busy) begin
          case (phase)
            PH_INIT: begin
              state_n = DELAY;
              cnt_n   = (idx == 2'd0) ? CW'(T_INIT1) :
                        (idx == 2'd1) ? CW'(T_INIT2) : CW'(T_CMD);
            end
            PH_HI: begin
              state_n = SEND_LO;
              phase_n = PH_LO;
              stb_n   = 1'b1;
              nyb_n   = byte_q[3:0];
            end
            default: begin
              state_n = DELAY;
              cnt_n   = long_q ? CW'(T_LONG) : CW'(T_CMD);
            end
          endcase
        end
      end
      DELAY: begin
        if (cnt <= CW'(1)) begin
          if (phase == PH_INIT && idx != 2'd3) begin
            state_n = INIT_SEND;
            idx_n   = idx + 2'd1;
            stb_n   = 1'b1;
            nyb_n   = (idx == 2'd2) ? 4'h2 : 4'h3;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end else cnt_n = cnt - CW'(1);
      end
      IDLE: begin
        if (STB_I) begin
          state_n = NS_WAIT;
          phase_n = PH_HI;
          first_n = 1'b1;
          rs_n    = i_rs;
          byte_n  = i_byte;
          long_n  = !i_rs && (i_byte[7:2] == 6'b0);
          stb_n   = 1'b1;
          ns_rs_n = i_rs;
          nyb_n   = i_byte[7:4];
        end
      end
      default: state_n = PWRWAIT;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_hd44780_byte_sequencer.sv
// Directed bench for hd44780_byte_sequencer with a 6-cycle nybble-sender model.
module tb_hd44780_byte_sequencer;

  logic       clk = 1'b0, rst = 1'b1, stb = 1'b0, rs = 1'b0;
  logic [7:0] byt = 8'h00;
  logic       busy, done, nstb, nrs, nsbusy;
  logic [3:0] nnyb;

  hd44780_byte_sequencer #(.T_POWERUP(20), .T_INIT1(10), .T_INIT2(5), .T_CMD(4), .T_LONG(12)) dut (
    .CLK_I(clk), .RST_I(rst), .STB_I(stb), .i_rs(rs), .i_byte(byt),
    .o_busy(busy), .o_init_done(done), .o_ns_stb(nstb), .o_ns_rs(nrs),
    .o_ns_nybble(nnyb), .i_ns_busy(nsbusy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int scnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sender model: busy for 6 cycles after it samples a strobe.
  always @(posedge clk) begin
    if (rst) scnt <= 0;
    else if (nstb) scnt <= 6;
    else if (scnt != 0) scnt <= scnt - 1;
  end
  assign nsbusy = (scnt != 0);

  // Monitor: log strobes and busy falls with the edge number that produced them.
  int         scyc[$];
  logic [3:0] snyb[$];
  logic       srs[$];
  int         nfalls = 0, fall_cyc = 0, dbl = 0, stab_bad = 0;
  logic       prev_stb = 1'b0, prev_busy = 1'b0, last_valid = 1'b0, last_rs = 1'b0;
  logic [3:0] last_nyb = 4'h0;
  always @(negedge clk) begin
    if (nstb === 1'b1) begin
      scyc.push_back(cyc); snyb.push_back(nnyb); srs.push_back(nrs);
      if (prev_stb === 1'b1) dbl++;
    end
    if (rst) last_valid = 1'b0;
    else if (nstb === 1'b1) begin
      last_valid = 1'b1; last_nyb = nnyb; last_rs = nrs;
    end else if (last_valid && (nnyb !== last_nyb || nrs !== last_rs)) stab_bad++;
    if (prev_busy === 1'b1 && busy === 1'b0) begin nfalls++; fall_cyc = cyc; end
    prev_stb  = nstb;
    prev_busy = busy;
  end

  int checks = 0, errors = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_fall(input int nf, input int bound, output bit ok);
    int n = 0;
    while (nfalls <= nf && n < bound) begin step(); n++; end
    ok = (nfalls > nf);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_init_done"}, done, 0);
    check({tag, "_ns_stb"}, nstb, 0);
    check({tag, "_ns_rs"}, nrs, 0);
    check({tag, "_ns_nybble"}, nnyb, 0);
  endtask

  // Init: strobes 3,3,3,2 at r+20 then gaps of 8+T; done 8+T_CMD after the last.
  task automatic run_init(input string tag, input int r, input int q0);
    int gap[3] = '{18, 13, 12};
    bit early = 0;
    int n = 0;
    int nf = nfalls;
    while (nfalls == nf && n < 300) begin
      if (done !== 1'b0) early = 1;
      step(); n++;
    end
    check({tag, "_completes"}, nfalls > nf, 1);
    check({tag, "_done_not_early"}, early, 0);
    check({tag, "_strobe_count"}, scyc.size() - q0, 4);
    if (scyc.size() >= q0 + 4) begin
      check({tag, "_first_strobe_cycle"}, scyc[q0] - r, 20);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("%s_nyb%0d", tag, k), snyb[q0+k], (k == 3) ? 2 : 3);
        check($sformatf("%s_rs%0d", tag, k), srs[q0+k], 0);
      end
      for (int k = 0; k < 3; k++)
        check($sformatf("%s_gap%0d", tag, k), scyc[q0+k+1] - scyc[q0+k], gap[k]);
      check({tag, "_final_delay"}, fall_cyc - scyc[q0+3], 12);
    end
    check({tag, "_init_done"}, done, 1);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] b;
    int         inj;   // steps after accept to pulse a bogus 0x3C request (0 = none)
    logic [3:0] hi;
    logic [3:0] lo;
    int         lat;   // accept edge to o_busy-fall edge
  } vec_t;
  vec_t vecs[8];

  initial begin
    int  q0, nf, t, n, f1, r;
    bit  ok;
    vecs[0] = '{1'b1, 8'hA5, 0,  4'hA, 4'h5, 20};
    vecs[1] = '{1'b0, 8'h01, 0,  4'h0, 4'h1, 28};
    vecs[2] = '{1'b1, 8'h01, 0,  4'h0, 4'h1, 20};
    vecs[3] = '{1'b0, 8'h02, 0,  4'h0, 4'h2, 28};
    vecs[4] = '{1'b0, 8'h03, 0,  4'h0, 4'h3, 28};
    vecs[5] = '{1'b0, 8'h04, 0,  4'h0, 4'h4, 20};
    vecs[6] = '{1'b1, 8'hC3, 3,  4'hC, 4'h3, 20};
    vecs[7] = '{1'b0, 8'h80, 18, 4'h8, 4'h0, 20};

    // Power-on reset and init
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    r = cyc;
    run_init("init", r, 0);

    // Table-driven byte transfers
    for (int i = 0; i < 8; i++) begin
      q0 = scyc.size(); nf = nfalls;
      rs = vecs[i].rs; byt = vecs[i].b; stb = 1'b1;
      step(); t = cyc; stb = 1'b0;
      n = 0;
      while (nfalls == nf && n < 100) begin
        step(); n++;
        if (n == vecs[i].inj) begin stb = 1'b1; byt = 8'h3C; rs = ~vecs[i].rs; end
        else if (n == vecs[i].inj + 1) stb = 1'b0;
      end
      check($sformatf("vec%0d_completes", i), nfalls > nf, 1);
      check($sformatf("vec%0d_latency", i), fall_cyc - t, vecs[i].lat);
      repeat (3) step();
      check($sformatf("vec%0d_strobe_count", i), scyc.size() - q0, 2);
      if (scyc.size() >= q0 + 2) begin
        check($sformatf("vec%0d_hi_cycle", i), scyc[q0] - t, 0);
        check($sformatf("vec%0d_lo_cycle", i), scyc[q0+1] - t, 8);
        check($sformatf("vec%0d_hi", i), snyb[q0], vecs[i].hi);
        check($sformatf("vec%0d_lo", i), snyb[q0+1], vecs[i].lo);
        check($sformatf("vec%0d_rs_hi", i), srs[q0], vecs[i].rs);
        check($sformatf("vec%0d_rs_lo", i), srs[q0+1], vecs[i].rs);
      end
    end

    // Reset between the high and low nybble
    rs = 1'b1; byt = 8'h5A; stb = 1'b1;
    step(); stb = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    q0 = scyc.size();
    step();
    check_reset_outputs("midreset");
    rst = 1'b0;
    r = cyc;
    run_init("reinit", r, q0);

    // Back-to-back: STB_I held high across IDLE re-entry
    q0 = scyc.size(); nf = nfalls;
    rs = 1'b0; byt = 8'h48; stb = 1'b1;
    step(); t = cyc;
    wait_fall(nf, 100, ok);
    check("b2b_first_completes", ok, 1);
    f1 = fall_cyc;
    check("b2b_first_latency", f1 - t, 20);
    step();
    check("b2b_restart_busy", busy, 1);
    check("b2b_restart_stb", nstb, 1);
    wait_fall(nf + 1, 100, ok);
    stb = 1'b0;
    check("b2b_second_completes", ok, 1);
    check("b2b_second_latency", fall_cyc - (f1 + 1), 20);
    repeat (10) step();
    check("b2b_strobe_count", scyc.size() - q0, 4);
    if (scyc.size() >= q0 + 4) begin
      check("b2b_s0_cycle", scyc[q0] - t, 0);
      check("b2b_s1_cycle", scyc[q0+1] - t, 8);
      check("b2b_s2_cycle", scyc[q0+2] - f1, 1);
      check("b2b_s3_cycle", scyc[q0+3] - f1, 9);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("b2b_nyb%0d", k), snyb[q0+k], (k % 2 == 0) ? 4 : 8);
        check($sformatf("b2b_rs%0d", k), srs[q0+k], 0);
      end
    end
    check("b2b_idle", busy, 0);

    check("no_double_strobe", dbl, 0);
    check("nybble_stable_between_strobes", stab_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000 ns");
    $fatal(1, "watchdog");
  end

endmodule
